arb_rr_mux_4b_8to1: RTL and testbench
=====================================

# arb_rr_mux_4b_8to1

Round-robin arbitrated 8-to-1 4-bit multiplexer with a one-entry registered output. Eight latency-insensitive (val/rdy) 4-bit request streams share one output stream. The block computes the mux select each cycle from the pending requests and a rotating priority pointer, then registers the winner's message together with its source index. It sits in front of any shared 4-bit consumer that several producers must reach through a single port.

## Interface
- No parameters; widths are fixed (8 ports, 4-bit messages).
- clk      input   1  clock; all state updates on rising edge
- reset    input   1  synchronous, active-high reset
- in_val   input   8  bit i: requester i presents a valid message
- in_rdy   output  8  bit i: requester i's message is accepted this cycle
- in0..in7 input   4  message from requester 0..7
- out_val  output  1  output register holds a valid message
- out_rdy  input   1  consumer accepts the output this cycle
- out      output  4  registered winning message
- out_src  output  3  registered index of the winning requester

## Operation
- Transfer on any port occurs when val and rdy are both high in the same cycle.
- State:
  - Priority pointer ptr (3 b).
  - Output entry: full flag (drives out_val), out, out_src.
- enq_en = !out_val || out_rdy. Pipelined flow: a full entry may drain and refill in the same cycle.
- Arbitration is combinational on in_val and ptr:
  - Scan indices ptr, ptr+1, …, ptr+7 (mod 8).
  - The first index with in_val set is the grant g.
  - No valid bit set means no grant.
- in_rdy = onehot(g) when enq_en and a grant exists, else 8'b0.
  - At most one in_rdy bit is high.
  - in_rdy never depends on in_rdy.
- On enqueue (grant && enq_en) at the clock edge:
  - out <= in[g], out_src <= g, out_val <= 1.
  - ptr <= g+1 mod 8; grant 7 wraps ptr to 0.
- On dequeue without enqueue: out_val <= 0. out and out_src hold their stale values.
- No enqueue: ptr holds. In particular, ptr does not move while the output is stalled, even if requests are pending.
- in_val bits may change freely while not granted; the block does not require requesters to hold.

## Timing
- Reset values: out_val=0, out=0, out_src=0, ptr=0, in_rdy=0. Reset mid-operation discards any held entry.
- in_rdy is combinational in the request cycle.
- Latency is 1 cycle: a message accepted in cycle N appears on out/out_val in cycle N+1.
- Throughput is 1 message per cycle while out_rdy stays high.
- Output stall (out_val=1, out_rdy=0):
  - All in_rdy are 0.
  - out, out_src and ptr hold.
- Simultaneous dequeue and enqueue: the new message replaces the old one, with no bubble.
- Fairness: a continuously asserting requester is granted within 8 enqueue opportunities.

## Structure
- Shared package arb_mux_pkg holds:
  - Localparams NPORTS=8, NBITS=4, SELBITS=3.
  - Typedef msg_t (logic [3:0]) and sel_t (logic [2:0]).
- Sub-module rr_arb_8 is the natural split:
  - Inputs clk, reset, req[8], en.
  - Outputs grant[8] (one-hot) and grant_idx (3 b).
  - It owns ptr and updates it only when en && |req.
- The top level holds enq_en, the select-driven 8-to-1 data mux and the output register.

## Test plan
- Reset: assert reset 2 cycles with all in_val=1 → in_rdy=0, out_val=0, out=0, out_src=0. First cycle after reset grants requester 0.
- Single requester: in_val=8'b0000_0100, in2=4'hA, out_rdy=1 every cycle.
  - in_rdy=8'b0000_0100 every cycle.
  - From the next cycle onward, out=A and out_src=2 each cycle.
- Full rotation: in_val=8'hFF, in_i=i+1, out_rdy=1.
  - out_src sequence is 0,1,…,7,0 (wrap after 7).
  - out follows 1..8,1.
- Stall: out_val=1 with out_src=3, then out_rdy=0 for 3 cycles with in_val=8'hFF.
  - in_rdy=0 throughout; out and out_src hold.
  - After out_rdy returns, the next out_src is 4.
- Sparse priority: ptr=6, in_val=8'b0010_0010 → grant 1, ptr becomes 2; then grant 5.
- Reset mid-stream: entry full (out=7), assert reset one cycle → out_val=0, ptr=0. Pending requests from 0 and 5 are granted to 0 first.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared widths and types for the round-robin arbitrated 8-to-1 4-bit mux.
package arb_mux_pkg;
    localparam int NPORTS  = 8;
    localparam int NBITS   = 4;
    localparam int SELBITS = 3;

    typedef logic [NBITS-1:0]   msg_t;
    typedef logic [SELBITS-1:0] sel_t;
endpackage

// File: rtl/arb_rr_mux_4b_8to1_if.sv
// Request/response bundle: eight val/rdy 4-bit producers and one val/rdy consumer.
interface arb_rr_mux_4b_8to1_if;
    import arb_mux_pkg::*;

    logic [NPORTS-1:0] in_val;
    logic [NPORTS-1:0] in_rdy;
    msg_t in0, in1, in2, in3, in4, in5, in6, in7;
    logic out_val;
    logic out_rdy;
    msg_t out;
    sel_t out_src;

    modport slave (
        input  in_val, in0, in1, in2, in3, in4, in5, in6, in7, out_rdy,
        output in_rdy, out_val, out, out_src
    );

    modport master (
        output in_val, in0, in1, in2, in3, in4, in5, in6, in7, out_rdy,
        input  in_rdy, out_val, out, out_src
    );
endinterface

// File: rtl/arb_rr_mux_4b_8to1_rr_arb_8.sv
// Eight-way round-robin arbiter; the pointer advances past the winner only on an accepted grant.
module rr_arb_8
    import arb_mux_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic              en,
    output logic [NPORTS-1:0] grant,
    output sel_t              grant_idx
);
    sel_t ptr_reg, ptr_next;
    sel_t scan_idx;
    logic found;

    // Scan from ptr upward with 3-bit wraparound; first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NPORTS; k++) begin
            scan_idx = ptr_reg + sel_t'(k);
            if (!found && req[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (en && found) begin
            ptr_next = grant_idx + sel_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
endmodule

// File: rtl/arb_rr_mux_4b_8to1.sv
// Round-robin 8-to-1 4-bit mux with a single pipelined output register tagged by source index.
module arb_rr_mux_4b_8to1
    import arb_mux_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    arb_rr_mux_4b_8to1_if.slave   bus
);
    msg_t              in_msg [NPORTS];
    logic [NPORTS-1:0] grant;
    sel_t              grant_idx;
    logic              enq_en;
    logic              enq_ok;
    logic              do_enq;

    logic out_val_reg;
    msg_t out_reg;
    sel_t out_src_reg;

    assign in_msg[0] = bus.in0;
    assign in_msg[1] = bus.in1;
    assign in_msg[2] = bus.in2;
    assign in_msg[3] = bus.in3;
    assign in_msg[4] = bus.in4;
    assign in_msg[5] = bus.in5;
    assign in_msg[6] = bus.in6;
    assign in_msg[7] = bus.in7;

    // Space exists if empty or draining this cycle; nothing is accepted while in reset.
    assign enq_en = !out_val_reg || bus.out_rdy;
    assign enq_ok = enq_en && !reset;
    assign do_enq = enq_ok && (|bus.in_val);

    rr_arb_8 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.in_val),
        .en        (enq_ok),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_rdy
            assign bus.in_rdy[gi] = enq_ok & grant[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out_val_reg <= 1'b0;
            out_reg     <= '0;
            out_src_reg <= '0;
        end else if (do_enq) begin
            out_val_reg <= 1'b1;
            out_reg     <= in_msg[grant_idx];
            out_src_reg <= grant_idx;
        end else if (bus.out_rdy) begin
            out_val_reg <= 1'b0;
        end
    end

    assign bus.out_val = out_val_reg;
    assign bus.out     = out_reg;
    assign bus.out_src = out_src_reg;
endmodule

// File: tb/tb_arb_rr_mux_4b_8to1.sv
// Scoreboard bench: stimulus predicts grants from a round-robin model; a monitor checks each output transfer.
module tb_arb_rr_mux_4b_8to1;
    import arb_mux_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    arb_rr_mux_4b_8to1_if bus();

    arb_rr_mux_4b_8to1 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] msg;
        logic [2:0] src;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         m_ptr  = 0;
    bit         m_full = 1'b0;
    logic [3:0] msgs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, then predict in_rdy from the pending set and the model pointer.
    task automatic step(input logic [7:0] v, input bit ordy, input bit rst);
        int         g;
        bit         enq;
        logic [7:0] exp_rdy;
        @(posedge clk);
        #1;
        reset       = rst;
        bus.in_val  = v;
        bus.out_rdy = ordy;
        bus.in0 = msgs[0]; bus.in1 = msgs[1]; bus.in2 = msgs[2]; bus.in3 = msgs[3];
        bus.in4 = msgs[4]; bus.in5 = msgs[5]; bus.in6 = msgs[6]; bus.in7 = msgs[7];
        #1;
        if (rst) begin
            chk("rst_in_rdy", bus.in_rdy, 0);
            sb.delete();
            m_ptr  = 0;
            m_full = 1'b0;
        end else begin
            chk("out_val", bus.out_val, m_full);
            enq = !m_full || ordy;
            g   = -1;
            for (int k = 0; k < 8; k++) begin
                if (g < 0 && v[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
            end
            exp_rdy = (enq && g >= 0) ? (8'b1 << g) : 8'b0;
            chk("in_rdy", bus.in_rdy, exp_rdy);
            if (enq && g >= 0) begin
                sb.push_back({msgs[g], 3'(g)});
                m_ptr  = (g + 1) % 8;
                m_full = 1'b1;
            end else if (ordy) begin
                m_full = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && bus.out_val === 1'b1 && bus.out_rdy === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer actual=src%0d/%0h required=none at %0t",
                         bus.out_src, bus.out, $time);
            end else begin
                e = sb.pop_front();
                chk("out_msg", bus.out, e.msg);
                chk("out_src", bus.out_src, e.src);
                $display("xfer src=%0d msg=%h (expected src=%0d msg=%h)",
                         bus.out_src, bus.out, e.src, e.msg);
            end
        end
    end

    initial begin
        bus.in_val  = '0;
        bus.out_rdy = 1'b0;
        for (int j = 0; j < 8; j++) msgs[j] = 4'(j + 1);

        // Reset with every requester asserting, then full rotation from pointer 0.
        step(8'hFF, 1'b1, 1'b1);
        step(8'hFF, 1'b1, 1'b1);
        chk("rst_out_val", bus.out_val, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_out_src", bus.out_src, 0);
        for (int n = 0; n < 9; n++) step(8'hFF, 1'b1, 1'b0);

        // Single requester 2 with message A.
        msgs[2] = 4'hA;
        for (int n = 0; n < 4; n++) step(8'b0000_0100, 1'b1, 1'b0);

        // Stall holding source 3.
        step(8'b0000_1000, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step(8'hFF, 1'b0, 1'b0);
            chk("stall_out", bus.out, msgs[3]);
            chk("stall_src", bus.out_src, 3);
        end
        step(8'hFF, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // Sparse priority: ptr to 6, then requests 1 and 5.
        step(8'b0010_0000, 1'b1, 1'b0);
        step(8'b0010_0010, 1'b1, 1'b0);
        step(8'b0010_0010, 1'b1, 1'b0);

        // Reset while the entry holds 7.
        for (int j = 0; j < 8; j++) msgs[j] = 4'h7;
        step(8'b0000_1000, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("held_out", bus.out, 4'h7);
        step(8'b0010_0001, 1'b1, 1'b1);
        for (int j = 0; j < 8; j++) msgs[j] = 4'(8 + j);
        step(8'b0010_0001, 1'b1, 1'b0);
        step(8'b0010_0001, 1'b1, 1'b0);

        // Randomized traffic with occasional stalls and resets.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] v;
            for (int j = 0; j < 8; j++) msgs[j] = 4'($urandom);
            v = 8'($urandom);
            if ($urandom_range(0, 1) == 0) v = v & 8'($urandom);
            step(v, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        end

        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
